tdc_meas_ctrl: RTL and testbench

TDC_MEAS_CTRL -- requirements
Module: tdc_meas_ctrl

---
 rtl/tdc_meas_if.sv | 52 +++++
 rtl/tdc_meas_ctrl.sv | 165 ++++++++++++++++
 tb/tb_tdc_meas_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/tdc_meas_if.sv
// tdc_meas_if: handshake and data bundle between the phase-detector
// measurement controller and its environment (TDC codes in, error out).
//
// Signals:
//   enable      master->slave  request continuous measurement cycles
//   up_therm    master->slave  UP thermometer code from the TDC (32b)
//   dwn_therm   master->slave  DWN thermometer code from the TDC (32b)
//   err_ready   master->slave  loop filter accepts the presented result
//   pd_clr      slave->master  one-cycle phase detector / TDC clear
//   err_valid   slave->master  phase_err/sat are valid
//   phase_err   slave->master  signed UP count - DWN count (7b)
//   sat         slave->master  either captured code was full scale
//   lock        slave->master  lock indicator
//   busy        slave->master  controller not idle
interface tdc_meas_if;
   logic        enable;
   logic [31:0] up_therm;
   logic [31:0] dwn_therm;
   logic        err_ready;
   logic        pd_clr;
   logic        err_valid;
   logic [6:0]  phase_err;
   logic        sat;
   logic        lock;
   logic        busy;

   modport master (
      output enable,
      output up_therm,
      output dwn_therm,
      output err_ready,
      input  pd_clr,
      input  err_valid,
      input  phase_err,
      input  sat,
      input  lock,
      input  busy
   );

   modport slave (
      input  enable,
      input  up_therm,
      input  dwn_therm,
      input  err_ready,
      output pd_clr,
      output err_valid,
      output phase_err,
      output sat,
      output lock,
      output busy
   );
endinterface

// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl: sequences clear / acquire / capture of a phase-detector
// TDC, converts the UP/DWN thermometer codes to a signed phase error,
// presents it with a valid/ready handshake and tracks loop lock.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   m      tdc_meas_if.slave (enable, codes, err handshake, lock, busy)
module tdc_meas_ctrl #(
   parameter int WINDOW   = 32,
   parameter int LOCK_TOL = 2,
   parameter int LOCK_CNT = 8
) (
   input  logic       clk,
   input  logic       reset,
   tdc_meas_if.slave  m
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ACQ,
      S_CAPT,
      S_CALC,
      S_PRES
   } state_t;

   state_t      state;
   logic [7:0]  acq_cnt;
   logic [31:0] up_q;
   logic [31:0] dwn_q;
   logic [3:0]  lock_cnt;

   logic        pd_clr_q;
   logic        err_valid_q;
   logic [6:0]  phase_err_q;
   logic        sat_q;
   logic        lock_q;
   logic        busy_q;

   // Plain population count: bubbles in the thermometer code are
   // tolerated because only the number of set bits matters.
   function automatic logic [5:0] popcnt(input logic [31:0] v);
      logic [5:0] c;
      c = '0;
      for (int i = 0; i < 32; i++) begin
         c = c + {5'd0, v[i]};
      end
      return c;
   endfunction

   logic [5:0] up_cnt;
   logic [5:0] dwn_cnt;
   logic [6:0] diff_c;
   logic       sat_c;

   always_comb begin
      up_cnt  = popcnt(up_q);
      dwn_cnt = popcnt(dwn_q);
      // 7-bit two's-complement subtraction covers -32..+32
      diff_c  = {1'b0, up_cnt} - {1'b0, dwn_cnt};
      sat_c   = (up_cnt == 6'd32) | (dwn_cnt == 6'd32);
   end

   logic [6:0] pe_abs;
   logic       in_lock;
   logic [3:0] lock_nxt;

   always_comb begin
      pe_abs  = phase_err_q[6] ? (7'd0 - phase_err_q) : phase_err_q;
      in_lock = (pe_abs <= 7'(LOCK_TOL)) & ~sat_q;
      if (!in_lock) begin
         lock_nxt = 4'd0;
      end else if (lock_cnt == 4'(LOCK_CNT)) begin
         lock_nxt = lock_cnt;
      end else begin
         lock_nxt = lock_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         acq_cnt     <= '0;
         up_q        <= '0;
         dwn_q       <= '0;
         lock_cnt    <= '0;
         pd_clr_q    <= 1'b0;
         err_valid_q <= 1'b0;
         phase_err_q <= '0;
         sat_q       <= 1'b0;
         lock_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (m.enable) begin
                  state    <= S_CLEAR;
                  pd_clr_q <= 1'b1;
                  busy_q   <= 1'b1;
               end
            end
            S_CLEAR: begin
               pd_clr_q <= 1'b0;
               if (!m.enable) begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
               end else begin
                  state   <= S_ACQ;
                  acq_cnt <= 8'(WINDOW);
               end
            end
            S_ACQ: begin
               if (!m.enable) begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
               end else if (acq_cnt == 8'd1) begin
                  state <= S_CAPT;
               end else begin
                  acq_cnt <= acq_cnt - 8'd1;
               end
            end
            S_CAPT: begin
               up_q  <= m.up_therm;
               dwn_q <= m.dwn_therm;
               state <= S_CALC;
            end
            S_CALC: begin
               phase_err_q <= diff_c;
               sat_q       <= sat_c;
               err_valid_q <= 1'b1;
               state       <= S_PRES;
            end
            S_PRES: begin
               if (m.err_ready) begin
                  err_valid_q <= 1'b0;
                  lock_cnt    <= lock_nxt;
                  lock_q      <= (lock_nxt == 4'(LOCK_CNT));
                  if (m.enable) begin
                     state    <= S_CLEAR;
                     pd_clr_q <= 1'b1;
                  end else begin
                     state  <= S_IDLE;
                     busy_q <= 1'b0;
                  end
               end
            end
            default: begin
               state       <= S_IDLE;
               pd_clr_q    <= 1'b0;
               err_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign m.pd_clr    = pd_clr_q;
   assign m.err_valid = err_valid_q;
   assign m.phase_err = phase_err_q;
   assign m.sat       = sat_q;
   assign m.lock      = lock_q;
   assign m.busy      = busy_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// tb_tdc_meas_ctrl: directed + randomized bench for tdc_meas_ctrl with
// a count-based reference model for phase error, saturation and lock.
module tb_tdc_meas_ctrl;

   localparam int W    = 32;
   localparam int TOL  = 2;
   localparam int LCNT = 8;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   tdc_meas_if bus ();

   tdc_meas_ctrl #(
      .WINDOW   (W),
      .LOCK_TOL (TOL),
      .LOCK_CNT (LCNT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .m     (bus)
   );

   int n_run  = 0;
   int n_fail = 0;
   int lk     = 0;
   bit in_clear = 1'b0;
   bit got;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] therm(input int n);
      logic [31:0] one;
      one = 32'd1;
      if (n >= 32) return '1;
      if (n <= 0) return '0;
      return (one << n) - 32'd1;
   endfunction

   // One full measurement: wait for the result, check it, optionally
   // stall the consumer, then complete the handshake.
   task automatic meas(input logic [31:0] u, input logic [31:0] d,
                       input int hold, input bit en_after);
      int k, k_clr, pulses, e_up, e_dn, pe, pa;
      bit e_sat, ok;
      logic [6:0] e_pe;
      e_up  = $countones(u);
      e_dn  = $countones(d);
      pe    = e_up - e_dn;
      pa    = (pe < 0) ? -pe : pe;
      e_sat = (e_up == 32) || (e_dn == 32);
      e_pe  = 7'(pe);
      bus.up_therm  = u;
      bus.dwn_therm = d;
      bus.enable    = 1'b1;
      bus.err_ready = 1'b0;
      pulses = in_clear ? 1 : 0;
      k_clr  = in_clear ? 0 : -1000;
      ok = 1'b0;
      for (k = 1; k <= W + 20; k++) begin
         @(negedge clk);
         if (bus.pd_clr) begin
            pulses++;
            k_clr = k;
         end
         if (bus.err_valid) begin
            ok = 1'b1;
            break;
         end
      end
      chk("valid_seen", ok, 1);
      chk("latency", k - k_clr, W + 3);
      chk("clr_pulses", pulses, 1);
      chk("phase_err", bus.phase_err, e_pe);
      chk("sat", bus.sat, e_sat);
      chk("busy_pres", bus.busy, 1);
      for (int h = 0; h < hold; h++) begin
         bus.enable = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("hold_valid", bus.err_valid, 1);
         chk("hold_pe", bus.phase_err, e_pe);
         chk("hold_sat", bus.sat, e_sat);
      end
      bus.err_ready = 1'b1;
      bus.enable    = en_after;
      if (pa <= TOL && !e_sat) lk = (lk < LCNT) ? lk + 1 : LCNT;
      else lk = 0;
      @(negedge clk);
      chk("hs_valid", bus.err_valid, 0);
      chk("lock", bus.lock, (lk == LCNT));
      chk("hs_pd_clr", bus.pd_clr, en_after);
      chk("hs_busy", bus.busy, en_after);
      chk("retain_pe", bus.phase_err, e_pe);
      chk("retain_sat", bus.sat, e_sat);
      bus.err_ready = 1'b0;
      in_clear = en_after;
   endtask

   initial begin
      int nu, nd;
      logic [31:0] cu, cd;

      reset         = 1'b1;
      bus.enable    = 1'b0;
      bus.err_ready = 1'b0;
      bus.up_therm  = '0;
      bus.dwn_therm = '0;
      repeat (2) @(negedge clk);
      chk("rst_valid", bus.err_valid, 0);
      chk("rst_pd_clr", bus.pd_clr, 0);
      chk("rst_pe", bus.phase_err, 0);
      chk("rst_sat", bus.sat, 0);
      chk("rst_lock", bus.lock, 0);
      chk("rst_busy", bus.busy, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_busy", bus.busy, 0);

      // basic +4 result, then full-scale DWN saturation
      meas(32'h0000_00FF, 32'h0000_000F, 0, 1'b0);
      meas(32'h0000_0003, 32'hFFFF_FFFF, 0, 1'b0);
      // consumer stalls for 10 cycles, then handshake starts CLEAR
      meas(32'h0000_00FF, 32'h0000_000F, 10, 1'b1);

      // eight +1 results back to back -> lock, then +5 drops it
      for (int i = 0; i < 8; i++) begin
         meas(32'h0000_0003, 32'h0000_0001, 0, 1'b1);
      end
      meas(32'h0000_003F, 32'h0000_0001, 0, 1'b0);

      // randomized codes near each other, with bubbles
      for (int i = 0; i < 24; i++) begin
         nd = int'($urandom_range(0, 32));
         nu = nd + int'($urandom_range(0, 6)) - 3;
         if (nu < 0) nu = 0;
         if (nu > 32) nu = 32;
         cu = therm(nu);
         cd = therm(nd);
         if ($urandom_range(0, 3) == 0) cu ^= (32'd1 << $urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) cd ^= (32'd1 << $urandom_range(0, 31));
         meas(cu, cd, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      // lock again at the tolerance boundary (+2), stay running
      if (in_clear) meas(therm(1), therm(31), 0, 1'b1);
      for (int i = 0; i < LCNT; i++) begin
         meas(therm(10), therm(8), 0, 1'b1);
      end

      // reset while a result is being presented
      got = 1'b0;
      for (int k = 0; k < W + 20; k++) begin
         @(negedge clk);
         if (bus.err_valid) begin
            got = 1'b1;
            break;
         end
      end
      chk("pres_reached", got, 1);
      chk("lock_pre_rst", bus.lock, 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", bus.err_valid, 0);
      chk("mid_rst_lock", bus.lock, 0);
      chk("mid_rst_pe", bus.phase_err, 0);
      chk("mid_rst_busy", bus.busy, 0);
      lk = 0;
      in_clear = 1'b0;
      bus.enable = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // one in-lock result so the lock counter is non-zero
      meas(therm(20), therm(21), 1, 1'b0);

      // abort during CLEAR
      bus.enable = 1'b1;
      @(negedge clk);
      chk("ab_clr_pulse", bus.pd_clr, 1);
      bus.enable = 1'b0;
      @(negedge clk);
      chk("ab_clr_busy", bus.busy, 0);

      // abort at ACQ cycle 10
      bus.enable = 1'b1;
      @(negedge clk);
      chk("ab_acq_pulse", bus.pd_clr, 1);
      repeat (10) @(negedge clk);
      bus.enable = 1'b0;
      @(negedge clk);
      chk("ab_acq_busy", bus.busy, 0);
      got = 1'b0;
      for (int k = 0; k < W + 8; k++) begin
         if (bus.err_valid || bus.pd_clr) got = 1'b1;
         @(negedge clk);
      end
      chk("ab_no_result", got, 0);
      chk("ab_lock", bus.lock, (lk == LCNT));

      // resume after abort; lock counter continues from before
      meas(therm(16), therm(15), 0, 1'b0);
      meas(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
